// File: rtl/rx_ack_nak_scheduler.sv
// Receive-side DLL Ack/Nak scheduler: classifies each received TLP against
// NEXT_RCV_SEQ and requests Ack/Nak DLLPs from the DLLP transmit arbiter.
module rx_ack_nak_scheduler #(
  parameter int seq_num_width = 12,
  parameter int ack_latency   = 64,
  parameter int timer_width   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tlp_done,
  input  logic [seq_num_width-1:0] tlp_seq_num,
  input  logic                     lcrc_ok,
  input  logic                     tlp_nullified,
  input  logic                     dllp_ack,
  output logic                     tlp_accept,
  output logic                     dllp_req,
  output logic                     dllp_type,
  output logic [seq_num_width-1:0] dllp_seq_num,
  output logic [seq_num_width-1:0] next_rcv_seq,
  output logic                     nak_scheduled,
  output logic                     ack_pending
);

  typedef enum logic [1:0] {IDLE, REQ_ACK, REQ_NAK} state_t;

  // Distances 1..2^(w-1) behind NEXT_RCV_SEQ are duplicates; larger ones mean a lost TLP.
  localparam logic [seq_num_width-1:0] dup_window = {1'b1, {(seq_num_width-1){1'b0}}};
  localparam logic [timer_width-1:0]   ack_trig   = timer_width'(ack_latency - 1);

  state_t state, state_nxt;

  logic                     nak_pend;
  logic                     ack_now;
  logic                     acc_since;
  logic [timer_width-1:0]   timer;
  logic [seq_num_width-1:0] seq_diff;
  logic [seq_num_width-1:0] next_seq_nxt;
  logic                     tlp_valid;
  logic                     accept_evt;
  logic                     dup_evt;
  logic                     nak_evt;
  logic                     nak_wait;
  logic                     ack_wait;
  logic                     timer_hit;
  logic                     ack_grant;
  logic                     nak_grant;
  logic                     capture;

  assign seq_diff     = next_rcv_seq - tlp_seq_num;
  assign tlp_valid    = tlp_done && !tlp_nullified;
  assign accept_evt   = tlp_valid && lcrc_ok && (seq_diff == '0);
  assign dup_evt      = tlp_valid && lcrc_ok && (seq_diff != '0) && (seq_diff <= dup_window);
  assign nak_evt      = tlp_valid && !nak_scheduled && (!lcrc_ok || (seq_diff > dup_window));
  assign next_seq_nxt = accept_evt ? next_rcv_seq + seq_num_width'(1) : next_rcv_seq;

  // Same-cycle events are folded in so a request can rise one cycle after tlp_done.
  assign nak_wait  = nak_pend || nak_evt;
  assign ack_wait  = ack_now || dup_evt;
  assign timer_hit = ack_pending && (timer >= ack_trig);
  assign ack_grant = dllp_ack && (state == REQ_ACK);
  assign nak_grant = dllp_ack && (state == REQ_NAK);
  assign capture   = (state == IDLE) && (state_nxt != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (nak_wait)                   state_nxt = REQ_NAK;
        else if (ack_wait || timer_hit) state_nxt = REQ_ACK;
      end
      REQ_ACK, REQ_NAK: begin
        if (dllp_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dllp_req = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tlp_accept    <= 1'b0;
      next_rcv_seq  <= '0;
      nak_scheduled <= 1'b0;
      ack_pending   <= 1'b0;
      nak_pend      <= 1'b0;
      ack_now       <= 1'b0;
      acc_since     <= 1'b0;
      timer         <= '0;
      dllp_type     <= 1'b0;
      dllp_seq_num  <= '0;
    end else begin
      tlp_accept   <= accept_evt;
      next_rcv_seq <= next_seq_nxt;

      if (accept_evt)   nak_scheduled <= 1'b0;
      else if (nak_evt) nak_scheduled <= 1'b1;

      if (nak_evt)        nak_pend <= 1'b1;
      else if (nak_grant) nak_pend <= 1'b0;

      if (dup_evt)        ack_now <= 1'b1;
      else if (ack_grant) ack_now <= 1'b0;

      // A TLP accepted after the Ack was captured keeps ack_pending alive.
      if (accept_evt)                    ack_pending <= 1'b1;
      else if (ack_grant && !acc_since)  ack_pending <= 1'b0;

      if (capture && (state_nxt == REQ_ACK)) acc_since <= 1'b0;
      else if (accept_evt)                   acc_since <= 1'b1;

      if (!ack_pending || (capture && (state_nxt == REQ_ACK)))
        timer <= '0;
      else if ((state == IDLE) && !nak_wait && !ack_wait && (timer < ack_trig))
        timer <= timer + timer_width'(1);

      if (capture) begin
        dllp_type    <= (state_nxt == REQ_NAK);
        dllp_seq_num <= next_seq_nxt - seq_num_width'(1);
      end
    end
  end

endmodule

// File: tb/tb_rx_ack_nak_scheduler.sv
// Scenario bench for rx_ack_nak_scheduler; expected DLLPs are queued at stimulus
// time and popped when the DUT raises its request.
module tb_rx_ack_nak_scheduler;

  localparam int SW  = 12;
  localparam int LAT = 8;
  localparam int TW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          tlp_done;
  logic [SW-1:0] tlp_seq_num;
  logic          lcrc_ok;
  logic          tlp_nullified;
  logic          dllp_ack;
  logic          tlp_accept;
  logic          dllp_req;
  logic          dllp_type;
  logic [SW-1:0] dllp_seq_num;
  logic [SW-1:0] next_rcv_seq;
  logic          nak_scheduled;
  logic          ack_pending;

  typedef struct packed {
    logic          t;
    logic [SW-1:0] s;
  } dllp_t;

  dllp_t sb[$];
  dllp_t exp_d;
  int    total = 0;
  int    bad   = 0;
  bit    found;
  int    cycles;

  rx_ack_nak_scheduler #(
    .seq_num_width(SW),
    .ack_latency  (LAT),
    .timer_width  (TW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tlp_done     (tlp_done),
    .tlp_seq_num  (tlp_seq_num),
    .lcrc_ok      (lcrc_ok),
    .tlp_nullified(tlp_nullified),
    .dllp_ack     (dllp_ack),
    .tlp_accept   (tlp_accept),
    .dllp_req     (dllp_req),
    .dllp_type    (dllp_type),
    .dllp_seq_num (dllp_seq_num),
    .next_rcv_seq (next_rcv_seq),
    .nak_scheduled(nak_scheduled),
    .ack_pending  (ack_pending)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [SW-1:0] s, input logic ok, input logic nul);
    tlp_done      = 1'b1;
    tlp_seq_num   = s;
    lcrc_ok       = ok;
    tlp_nullified = nul;
    tick();
    tlp_done      = 1'b0;
    tlp_nullified = 1'b0;
    lcrc_ok       = 1'b1;
  endtask

  task automatic grant;
    dllp_ack = 1'b1;
    tick();
    dllp_ack = 1'b0;
  endtask

  task automatic wait_req(input int budget, output bit f, output int n);
    n = 0;
    while (!dllp_req && n < budget) begin
      tick();
      n++;
    end
    f = dllp_req;
  endtask

  task automatic do_reset;
    tlp_done = 1'b0; dllp_ack = 1'b0; tlp_nullified = 1'b0; lcrc_ok = 1'b1;
    tlp_seq_num = '0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b0; tlp_done = 1'b0; dllp_ack = 1'b0; tlp_nullified = 1'b0;
    lcrc_ok = 1'b1; tlp_seq_num = '0;
    tick(); tick();
    total++;
    if ({tlp_accept, dllp_req, dllp_type, dllp_seq_num, next_rcv_seq, nak_scheduled, ack_pending} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got req=%b type=%b dseq=%0d nrs=%0d nak=%b ackp=%b acc=%b want all 0",
               dllp_req, dllp_type, dllp_seq_num, next_rcv_seq, nak_scheduled, ack_pending, tlp_accept);
    end
    send(12'd0, 1'b1, 1'b0);
    total++;
    if (tlp_accept !== 1'b0 || next_rcv_seq !== 12'd0) begin
      bad++;
      $display("[TB] FAIL reset_blocks_tlp: got acc=%b nrs=%0d want acc=0 nrs=0", tlp_accept, next_rcv_seq);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_timed_ack;
    do_reset();
    sb.push_back('{t: 1'b0, s: 12'd2});
    for (int i = 0; i < 3; i++) begin
      send(SW'(i), 1'b1, 1'b0);
      total++;
      if (tlp_accept !== 1'b1 || next_rcv_seq !== SW'(i + 1)) begin
        bad++;
        $display("[TB] FAIL inorder_accept[%0d]: got acc=%b nrs=%0d want acc=1 nrs=%0d", i, tlp_accept, next_rcv_seq, i + 1);
      end
    end
    total++;
    if (ack_pending !== 1'b1 || dllp_req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ackpend_before_timer: got ackp=%b req=%b want ackp=1 req=0", ack_pending, dllp_req);
    end
    wait_req(LAT + 4, found, cycles);
    total++;
    if (found !== 1'b1 || cycles !== LAT - 2) begin
      bad++;
      $display("[TB] FAIL timed_ack_latency: got found=%b cycles=%0d want found=1 cycles=%0d", found, cycles, LAT - 2);
    end
    exp_d = sb.pop_front();
    total++;
    if (dllp_type !== exp_d.t || dllp_seq_num !== exp_d.s) begin
      bad++;
      $display("[TB] FAIL timed_ack_fields: got type=%b seq=%0d want type=%b seq=%0d", dllp_type, dllp_seq_num, exp_d.t, exp_d.s);
    end
    grant();
    total++;
    if (dllp_req !== 1'b0 || ack_pending !== 1'b0) begin
      bad++;
      $display("[TB] FAIL timed_ack_grant: got req=%b ackp=%b want req=0 ackp=0", dllp_req, ack_pending);
    end
    cycles = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      tick();
      if (dllp_req) cycles++;
    end
    total++;
    if (cycles !== 0) begin
      bad++;
      $display("[TB] FAIL no_extra_ack: got %0d request cycles want 0", cycles);
    end
  endtask

  task automatic test_nak;
    do_reset();
    send(12'd0, 1'b1, 1'b0);
    sb.push_back('{t: 1'b1, s: 12'd0});
    send(12'd1, 1'b0, 1'b0);
    total++;
    if (dllp_req !== 1'b1 || tlp_accept !== 1'b0 || nak_scheduled !== 1'b1 || next_rcv_seq !== 12'd1) begin
      bad++;
      $display("[TB] FAIL crc_nak: got req=%b acc=%b nak=%b nrs=%0d want req=1 acc=0 nak=1 nrs=1",
               dllp_req, tlp_accept, nak_scheduled, next_rcv_seq);
    end
    exp_d = sb.pop_front();
    total++;
    if (dllp_type !== exp_d.t || dllp_seq_num !== exp_d.s) begin
      bad++;
      $display("[TB] FAIL crc_nak_fields: got type=%b seq=%0d want type=%b seq=%0d", dllp_type, dllp_seq_num, exp_d.t, exp_d.s);
    end
    grant();
    total++;
    if (dllp_req !== 1'b0 || nak_scheduled !== 1'b1) begin
      bad++;
      $display("[TB] FAIL nak_grant: got req=%b nak=%b want req=0 nak=1", dllp_req, nak_scheduled);
    end
    send(12'd1, 1'b0, 1'b0);
    cycles = dllp_req ? 1 : 0;
    tick();
    if (dllp_req) cycles++;
    total++;
    if (cycles !== 0) begin
      bad++;
      $display("[TB] FAIL second_bad_no_nak: got %0d request cycles want 0", cycles);
    end
    sb.push_back('{t: 1'b0, s: 12'd1});
    send(12'd1, 1'b1, 1'b0);
    total++;
    if (tlp_accept !== 1'b1 || nak_scheduled !== 1'b0 || next_rcv_seq !== 12'd2) begin
      bad++;
      $display("[TB] FAIL retry_accept: got acc=%b nak=%b nrs=%0d want acc=1 nak=0 nrs=2", tlp_accept, nak_scheduled, next_rcv_seq);
    end
    wait_req(2 * LAT, found, cycles);
    exp_d = sb.pop_front();
    total++;
    if (found !== 1'b1 || dllp_type !== exp_d.t || dllp_seq_num !== exp_d.s) begin
      bad++;
      $display("[TB] FAIL retry_ack: got found=%b type=%b seq=%0d want found=1 type=%b seq=%0d",
               found, dllp_type, dllp_seq_num, exp_d.t, exp_d.s);
    end
    grant();
    total++;
    if (ack_pending !== 1'b0) begin
      bad++;
      $display("[TB] FAIL retry_ack_clear: got ackp=%b want 0", ack_pending);
    end
  endtask

  task automatic test_duplicate;
    do_reset();
    for (int i = 0; i < 5; i++) send(SW'(i), 1'b1, 1'b0);
    sb.push_back('{t: 1'b0, s: 12'd4});
    send(12'd0, 1'b1, 1'b0);
    total++;
    if (tlp_accept !== 1'b0 || dllp_req !== 1'b1 || next_rcv_seq !== 12'd5) begin
      bad++;
      $display("[TB] FAIL dup_ack_now: got acc=%b req=%b nrs=%0d want acc=0 req=1 nrs=5", tlp_accept, dllp_req, next_rcv_seq);
    end
    exp_d = sb.pop_front();
    total++;
    if (dllp_type !== exp_d.t || dllp_seq_num !== exp_d.s) begin
      bad++;
      $display("[TB] FAIL dup_ack_fields: got type=%b seq=%0d want type=%b seq=%0d", dllp_type, dllp_seq_num, exp_d.t, exp_d.s);
    end
    grant();
    total++;
    if (ack_pending !== 1'b0 || dllp_req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL dup_ack_grant: got ackp=%b req=%b want ackp=0 req=0", ack_pending, dllp_req);
    end
    send(12'd5, 1'b0, 1'b1);
    send(12'd5, 1'b1, 1'b1);
    tick();
    total++;
    if ({tlp_accept, dllp_req, nak_scheduled, ack_pending} !== 4'b0000 || next_rcv_seq !== 12'd5) begin
      bad++;
      $display("[TB] FAIL nullified_ignored: got acc=%b req=%b nak=%b ackp=%b nrs=%0d want 0 0 0 0 nrs=5",
               tlp_accept, dllp_req, nak_scheduled, ack_pending, next_rcv_seq);
    end
    sb.push_back('{t: 1'b1, s: 12'd4});
    send(12'd7, 1'b1, 1'b0);
    exp_d = sb.pop_front();
    total++;
    if (dllp_req !== 1'b1 || nak_scheduled !== 1'b1 || tlp_accept !== 1'b0 || next_rcv_seq !== 12'd5 ||
        dllp_type !== exp_d.t || dllp_seq_num !== exp_d.s) begin
      bad++;
      $display("[TB] FAIL future_nak: got req=%b nak=%b acc=%b nrs=%0d type=%b seq=%0d want 1 1 0 nrs=5 type=%b seq=%0d",
               dllp_req, nak_scheduled, tlp_accept, next_rcv_seq, dllp_type, dllp_seq_num, exp_d.t, exp_d.s);
    end
    grant();
  endtask

  task automatic test_wrap;
    int acc_cnt;
    int nak_seen;
    do_reset();
    acc_cnt  = 0;
    nak_seen = 0;
    for (int i = 0; i < 4096; i++) begin
      tlp_done    = 1'b1;
      tlp_seq_num = SW'(i);
      lcrc_ok     = 1'b1;
      dllp_ack    = dllp_req;
      tick();
      if (tlp_accept) acc_cnt++;
      if (dllp_req && dllp_type) nak_seen++;
    end
    tlp_done = 1'b0;
    dllp_ack = 1'b0;
    total++;
    if (acc_cnt !== 4096 || next_rcv_seq !== 12'd0 || nak_seen !== 0) begin
      bad++;
      $display("[TB] FAIL wrap_to_zero: got accepts=%0d nrs=%0d naks=%0d want 4096 0 0", acc_cnt, next_rcv_seq, nak_seen);
    end
    for (int k = 0; k < 4 && dllp_req; k++) grant();
    send(12'd0, 1'b1, 1'b0);
    total++;
    if (tlp_accept !== 1'b1 || next_rcv_seq !== 12'd1) begin
      bad++;
      $display("[TB] FAIL wrap_seq0: got acc=%b nrs=%0d want acc=1 nrs=1", tlp_accept, next_rcv_seq);
    end
    for (int k = 0; k < 4 && dllp_req; k++) grant();
    sb.push_back('{t: 1'b0, s: 12'd0});
    send(12'd4095, 1'b1, 1'b0);
    exp_d = sb.pop_front();
    total++;
    if (dllp_req !== 1'b1 || tlp_accept !== 1'b0 || next_rcv_seq !== 12'd1 ||
        dllp_type !== exp_d.t || dllp_seq_num !== exp_d.s) begin
      bad++;
      $display("[TB] FAIL wrap_dup_4095: got req=%b acc=%b nrs=%0d type=%b seq=%0d want 1 0 nrs=1 type=%b seq=%0d",
               dllp_req, tlp_accept, next_rcv_seq, dllp_type, dllp_seq_num, exp_d.t, exp_d.s);
    end
    grant();
  endtask

  task automatic test_stall;
    int unstable;
    do_reset();
    sb.push_back('{t: 1'b0, s: 12'd0});
    send(12'd0, 1'b1, 1'b0);
    wait_req(LAT + 4, found, cycles);
    exp_d = sb.pop_front();
    total++;
    if (found !== 1'b1 || dllp_type !== exp_d.t || dllp_seq_num !== exp_d.s) begin
      bad++;
      $display("[TB] FAIL stall_ack: got found=%b type=%b seq=%0d want found=1 type=%b seq=%0d",
               found, dllp_type, dllp_seq_num, exp_d.t, exp_d.s);
    end
    unstable = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 3) begin
        sb.push_back('{t: 1'b1, s: 12'd0});
        send(12'd1, 1'b0, 1'b0);
      end else begin
        tick();
      end
      if (dllp_req !== 1'b1 || dllp_type !== 1'b0 || dllp_seq_num !== 12'd0) unstable++;
    end
    total++;
    if (unstable !== 0 || nak_scheduled !== 1'b1) begin
      bad++;
      $display("[TB] FAIL stall_stable: got unstable=%0d nak=%b want 0 nak=1", unstable, nak_scheduled);
    end
    grant();
    total++;
    if (dllp_req !== 1'b0 || ack_pending !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stall_grant_idle: got req=%b ackp=%b want req=0 ackp=0", dllp_req, ack_pending);
    end
    tick();
    exp_d = sb.pop_front();
    total++;
    if (dllp_req !== 1'b1 || dllp_type !== exp_d.t || dllp_seq_num !== exp_d.s) begin
      bad++;
      $display("[TB] FAIL queued_nak: got req=%b type=%b seq=%0d want req=1 type=%b seq=%0d",
               dllp_req, dllp_type, dllp_seq_num, exp_d.t, exp_d.s);
    end
    #3;
    rst = 1'b0;
    #1;
    total++;
    if ({tlp_accept, dllp_req, dllp_type, dllp_seq_num, next_rcv_seq, nak_scheduled, ack_pending} !== '0) begin
      bad++;
      $display("[TB] FAIL async_reset: got req=%b type=%b dseq=%0d nrs=%0d nak=%b ackp=%b want all 0",
               dllp_req, dllp_type, dllp_seq_num, next_rcv_seq, nak_scheduled, ack_pending);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back;
    do_reset();
    sb.push_back('{t: 1'b0, s: 12'd0});
    send(12'd0, 1'b1, 1'b0);
    wait_req(LAT + 4, found, cycles);
    exp_d = sb.pop_front();
    total++;
    if (found !== 1'b1 || cycles !== LAT || dllp_seq_num !== exp_d.s || dllp_type !== exp_d.t) begin
      bad++;
      $display("[TB] FAIL b2b_first_ack: got found=%b cycles=%0d seq=%0d type=%b want 1 %0d seq=%0d type=%b",
               found, cycles, dllp_seq_num, dllp_type, LAT, exp_d.s, exp_d.t);
    end
    sb.push_back('{t: 1'b0, s: 12'd1});
    dllp_ack = 1'b1;
    send(12'd1, 1'b1, 1'b0);
    dllp_ack = 1'b0;
    total++;
    if (tlp_accept !== 1'b1 || dllp_req !== 1'b0 || ack_pending !== 1'b1) begin
      bad++;
      $display("[TB] FAIL grant_with_tlp: got acc=%b req=%b ackp=%b want acc=1 req=0 ackp=1", tlp_accept, dllp_req, ack_pending);
    end
    wait_req(2 * LAT, found, cycles);
    exp_d = sb.pop_front();
    total++;
    if (found !== 1'b1 || cycles !== LAT || dllp_seq_num !== exp_d.s || dllp_type !== exp_d.t) begin
      bad++;
      $display("[TB] FAIL b2b_restart_ack: got found=%b cycles=%0d seq=%0d type=%b want 1 %0d seq=%0d type=%b",
               found, cycles, dllp_seq_num, dllp_type, LAT, exp_d.s, exp_d.t);
    end
    grant();
    total++;
    if (ack_pending !== 1'b0) begin
      bad++;
      $display("[TB] FAIL b2b_final_clear: got ackp=%b want 0", ack_pending);
    end
  endtask

  initial begin
    test_reset();
    test_timed_ack();
    test_nak();
    test_duplicate();
    test_wrap();
    test_stall();
    test_back_to_back();
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drained: got %0d entries left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
